// File: rtl/sum_scale_fifo_pkg.sv
// Purpose: shared widths, saturation limits, result word type and the scale/round/saturate helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package sum_scale_fifo_pkg;

  localparam int SUM_W           = 15;
  localparam int OUT_W           = 12;
  localparam int SAT_MAX         = 2047;
  localparam int SAT_MIN         = -2048;
  localparam int ADD_LAT_DEFAULT = 5;
  // Internal width for the rounded sum: the 15-bit sum plus the rounding
  // constant cannot overflow 17 signed bits.
  localparam int CALC_W          = 17;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } res_t;

  // Round half toward +inf, arithmetic right shift, then clamp to OUT_W signed.
  function automatic res_t scale_sat(input logic signed [SUM_W-1:0] s,
                                     input logic [1:0]              sh);
    logic signed [CALC_W-1:0] t;
    logic signed [CALC_W-1:0] r;
    res_t                     o;
    t = CALC_W'(s);
    if (sh != 2'd0) begin
      t = t + (CALC_W'(1) << (sh - 2'd1));
    end
    r = t >>> sh;
    if (int'(r) > SAT_MAX) begin
      o.sat  = 1'b1;
      o.data = OUT_W'(SAT_MAX);
    end else if (int'(r) < SAT_MIN) begin
      o.sat  = 1'b1;
      o.data = OUT_W'(SAT_MIN);
    end else begin
      o.sat  = 1'b0;
      o.data = r[OUT_W-1:0];
    end
    return o;
  endfunction

endpackage

// File: rtl/sum_scale_fifo_if.sv
// Purpose: bundles the adder-tree input side and the FIFO output side of sum_scale_fifo.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer; the producer side has none (excess results are dropped).
// Ports: master = stimulus/consumer side, slave = sum_scale_fifo.
interface sum_scale_fifo_if
  import sum_scale_fifo_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic                           in_valid;
  logic signed [SUM_W-1:0]        sum;
  logic [1:0]                     shift;
  logic                           out_ready;
  logic                           clr_drop;
  logic                           out_valid;
  logic signed [OUT_W-1:0]        out_data;
  logic                           out_sat;
  logic [$clog2(DEPTH):0]         level;
  logic                           drop;

  modport master (
    output in_valid, sum, shift, out_ready, clr_drop,
    input  out_valid, out_data, out_sat, level, drop
  );

  modport slave (
    input  in_valid, sum, shift, out_ready, clr_drop,
    output out_valid, out_data, out_sat, level, drop
  );
endinterface

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO, DEPTH words of WIDTH bits, power-of-two DEPTH >= 2.
// Latency: a pushed word is visible at pop_dat on the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens on the same edge.
// Ports: push/push_dat write side, pop/pop_dat read side (pop_dat reads 0 when empty), full, empty, level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_acc;
  logic             pop_acc;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_acc  = pop && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push_acc = push && (!full || pop_acc);
  // Storage is not reset, so the head is masked to keep reset/empty reads at 0.
  assign pop_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/sum_scale_fifo.sv
// Purpose: aligns in_valid with the adder-tree sum, scales/rounds/saturates it and queues the result.
// Latency: ADD_LAT+1 cycles from in_valid to out_valid on an empty FIFO (no bypass).
// Backpressure: out_ready pops the head; a result arriving while full (and no pop) is dropped and sets sticky drop.
// Ports: clk, rst_n (async active-low), bus (slave modport of sum_scale_fifo_if).
module sum_scale_fifo
  import sum_scale_fifo_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEFAULT,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_scale_fifo_if.slave  bus
);
  logic [ADD_LAT-1:0] vld_pipe;
  logic               aligned;
  logic               pop;
  logic               full;
  logic               empty;
  logic               refused;
  res_t               res;
  res_t               head;

  // Last stage is high exactly in the cycle the matching sum leaves the adder tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.in_valid;
      for (int i = 1; i < ADD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign aligned = vld_pipe[ADD_LAT-1];
  assign res     = scale_sat(bus.sum, bus.shift);
  assign pop     = bus.out_ready && !empty;
  assign refused = aligned && full && !pop;

  sync_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (aligned),
    .push_dat (res),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .level    (bus.level)
  );

  // A discard in the same cycle as clr_drop keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.drop <= 1'b0;
    end else if (refused) begin
      bus.drop <= 1'b1;
    end else if (bus.clr_drop) begin
      bus.drop <= 1'b0;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = head.data;
  assign bus.out_sat   = head.sat;
endmodule

// File: tb/tb_sum_scale_fifo.sv
module tb_sum_scale_fifo;
  import sum_scale_fifo_pkg::*;

  localparam int ADD_LAT = 5;
  localparam int DEPTH   = 4;

  typedef struct {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_scale_fifo_if #(.DEPTH(DEPTH)) bus();

  sum_scale_fifo #(.ADD_LAT(ADD_LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Upstream adder-tree model: the operands issued with in_valid come out ADD_LAT cycles later.
  logic signed [SUM_W-1:0] req_sum;
  logic [1:0]              req_sh;
  logic signed [SUM_W-1:0] p_sum [ADD_LAT];
  logic [1:0]              p_sh  [ADD_LAT];

  always @(posedge clk) begin
    p_sum[0] <= req_sum;
    p_sh[0]  <= req_sh;
    for (int i = 1; i < ADD_LAT; i++) begin
      p_sum[i] <= p_sum[i-1];
      p_sh[i]  <= p_sh[i-1];
    end
  end
  assign bus.sum   = p_sum[ADD_LAT-1];
  assign bus.shift = p_sh[ADD_LAT-1];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted output word is compared to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(bus.out_data), int'(e.data));
          check("out_sat", int'(bus.out_sat), int'(e.sat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int sh, input int ed, input int es, input bit keep);
    exp_t e;
    bus.in_valid = 1'b1;
    req_sum      = SUM_W'(s);
    req_sh       = 2'(sh);
    if (keep) begin
      e.sat  = 1'(es);
      e.data = OUT_W'(ed);
      exp_q.push_back(e);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (ADD_LAT + 1) tick();
    for (int i = 0; i < 60 && bus.out_valid; i++) tick();
    check("drain_done", int'(bus.out_valid), 0);
  endtask

  // Directed vectors: sum, shift, expected data, expected sat.
  int tv_sum [10] = '{3000, -16384, 6, -6, -3, -16384, 4095, -2048, 16383, -5};
  int tv_sh  [10] = '{0,    0,      2, 2,  1,  3,      1,    0,     3,     2};
  int tv_dat [10] = '{2047, -2048,  2, -1, -1, -2048,  2047, -2048, 2047,  -1};
  int tv_sat [10] = '{1,    1,      0, 0,  0,  0,      1,    0,     1,     0};

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_drop  = 1'b0;
    req_sum       = '0;
    req_sh        = '0;
    repeat (2) tick();

    // Reset state
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_drop", int'(bus.drop), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    rst_n = 1'b1;
    tick();

    // Latency: out_valid rises ADD_LAT+1 cycles after in_valid
    bus.out_ready = 1'b1;
    send(16376, 3, 2047, 0, 1'b1);
    repeat (4) tick();
    check("lat_early", int'(bus.out_valid), 0);
    tick();
    check("lat_rise", int'(bus.out_valid), 1);
    drain();

    // Scaling, rounding and saturation patterns, back to back
    for (int i = 0; i < 10; i++) send(tv_sum[i], tv_sh[i], tv_dat[i], tv_sat[i], 1'b1);
    drain();

    // Overflow: 6 results into a 4-deep FIFO with no consumer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(i + 1, 0, i + 1, 0, i < 4);
    repeat (4) tick();
    check("ovf_level", int'(bus.level), 4);
    check("ovf_drop", int'(bus.drop), 1);
    bus.clr_drop = 1'b1;            // coincides with the second discard
    tick();
    bus.clr_drop = 1'b0;
    check("drop_set_wins", int'(bus.drop), 1);
    bus.clr_drop = 1'b1;
    tick();
    bus.clr_drop = 1'b0;
    check("drop_cleared", int'(bus.drop), 0);
    check("ovf_level_hold", int'(bus.level), 4);
    drain();
    check("ovf_drop_after", int'(bus.drop), 0);

    // Full FIFO with push and pop on the same edge
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(10 + i, 0, 10 + i, 0, 1'b1);
    repeat (4) tick();
    check("full_before", int'(bus.level), 4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("full_pushpop_level", int'(bus.level), 4);
    check("full_pushpop_drop", int'(bus.drop), 0);
    drain();

    // Reset with 2 queued and 3 in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(21 + i, 0, 21 + i, 0, 1'b1);
    repeat (2) tick();
    check("pre_reset_level", int'(bus.level), 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_level", int'(bus.level), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (12) tick();
    check("post_reset_level", int'(bus.level), 0);
    check("post_reset_valid", int'(bus.out_valid), 0);
    send(100, 2, 25, 0, 1'b1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sum_scale_fifo.md
SUM_SCALE_FIFO -- requirements
Module: sum_scale_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (ports clk and rst_n).
REQ-002 Parameter ADD_LAT, default 5, SHALL be the pipeline latency in clk cycles of the upstream 8-input 12-bit adder tree.
REQ-003 Parameter DEPTH, default 4, SHALL be the output FIFO depth in words (power of two, at least 2).
REQ-004 clk  input  1  rising-edge clock shared with the adder tree.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  high in the cycle the eight operands are presented to the adder tree.
REQ-007 sum  input  15  signed two's-complement adder-tree output, valid ADD_LAT cycles after in_valid.
REQ-008 shift  input  2  right-shift amount 0..3 (3 = average of 8).
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 clr_drop  input  1  clears the drop flag.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_data  output  12  signed scaled result at the FIFO head.
REQ-013 out_sat  output  1  set when the head word was saturated.
REQ-014 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 drop  output  1  sticky flag: a result was discarded because the FIFO was full.

Function
REQ-016 A valid delay line of ADD_LAT flops SHALL carry in_valid, so its last stage is high exactly in the cycle the matching sum is valid.
REQ-017 When the aligned valid is high, the block SHALL compute r = (sum + (shift>0 ? 2^(shift-1) : 0)) >>> shift with at least 16-bit signed width (round half toward +inf).
REQ-018 r SHALL saturate to [-2048, 2047]; the sat bit SHALL be 1 only when clamping occurred.
REQ-019 {sat, r[11:0]} SHALL be written into the FIFO at the clk edge ending the aligned-valid cycle; shift SHALL be sampled in that same cycle.
REQ-020 Latency SHALL be ADD_LAT+1 cycles from in_valid to out_valid when the FIFO is empty, with no bypass path.
REQ-021 A pop SHALL occur on each edge where out_valid and out_ready are both high; out_data and out_sat SHALL present the oldest word; order SHALL be FIFO.
REQ-022 A push SHALL be accepted when level < DEPTH, or when level == DEPTH with a simultaneous pop; in the latter case level SHALL stay DEPTH.
REQ-023 A push refused while full SHALL discard the word, leave FIFO contents unchanged, and set drop.
REQ-024 drop SHALL clear on clr_drop; if a discard and clr_drop occur in the same cycle, drop SHALL remain 1 (set wins).
REQ-025 Push and pop in the same cycle on an empty FIFO SHALL be impossible; the push lands and out_valid rises on the next cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear the valid delay line, pointers, level, drop and out_valid, regardless of clk.
REQ-028 out_data and out_sat SHALL read 0 during reset; FIFO storage need not be reset.
REQ-029 In-flight sums whose in_valid occurred before reset SHALL never be written after reset deasserts.

Structure
REQ-030 A shared package SHALL hold SUM_W=15, OUT_W=12, SAT_MAX=2047, SAT_MIN=-2048 and the default ADD_LAT=5.
REQ-031 The FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty/level ports; the valid delay line and scaler SHALL remain in the top module.

Verification
REQ-032 Scaling: in_valid pulse, sum=16376, shift=3 -> out_valid rises 6 cycles later with out_data=2047, out_sat=0.
REQ-033 Saturation: shift=0, sum=3000 -> out_data=2047, out_sat=1; sum=-16384 -> out_data=-2048, out_sat=1.
REQ-034 Rounding: shift=2, sum=6 -> 2; shift=2, sum=-6 -> -1; shift=1, sum=-3 -> -1; all with out_sat=0.
REQ-035 Overflow: out_ready=0, 6 consecutive in_valid -> level=4, drop=1; pulse clr_drop, then out_ready=1 -> the first 4 results pop in order, drop=0.
REQ-036 Full plus simultaneous push and pop: level=4, out_ready=1, aligned valid -> level stays 4, drop stays 0, order preserved.
REQ-037 Reset mid-stream: rst_n low for 1 cycle with 3 results in flight and 2 queued -> out_valid=0 and level=0 at once; no output appears afterward until a new in_valid.
